// File: rtl/timer_display_decoder_if.sv
// timer_display_decoder_if
//   Bundles the countdown-timer sample, game-state inputs and the HUD-facing
//   digit/flag outputs of timer_display_decoder.
//   master: the timer/HUD side (drives clock_time, lose_game, win_game)
//   slave : the decoder (drives digits, digits_valid, busy and HUD flags)
interface timer_display_decoder_if;
    logic [7:0] clock_time;
    logic       lose_game;
    logic       win_game;
    logic [1:0] bcd_hundreds;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       digits_valid;
    logic       busy;
    logic       low_time;
    logic       blink_on;
    logic       time_expired;
    logic [2:0] digit_blank;

    modport master (
        output clock_time, lose_game, win_game,
        input  bcd_hundreds, bcd_tens, bcd_ones, digits_valid, busy,
               low_time, blink_on, time_expired, digit_blank
    );

    modport slave (
        input  clock_time, lose_game, win_game,
        output bcd_hundreds, bcd_tens, bcd_ones, digits_valid, busy,
               low_time, blink_on, time_expired, digit_blank
    );
endinterface

// File: rtl/timer_display_decoder.sv
// timer_display_decoder
//   Samples the 8-bit binary countdown value, converts it serially
//   (shift-and-add-3, 8 shifts) into registered BCD digits for the HUD,
//   and drives the low-time blink and time-expired flags.
// Ports:
//   frame_clk       frame clock, rising edge
//   game_restart_n  asynchronous active-low reset
//   bus (slave)     clock_time/lose_game/win_game in;
//                   bcd_hundreds/tens/ones, digits_valid, busy, low_time,
//                   blink_on, time_expired, digit_blank out
// Optional feature macro: TIMER_LEADING_ZERO_BLANK_EN
//   defined  : digit_blank registered at DONE (leading-zero blanking)
//   undefined: digit_blank tied to 3'b000
module timer_display_decoder #(
    parameter logic [7:0] LOW_THRESH   = 8'd10,
    parameter logic [7:0] BLINK_FRAMES = 8'd15
) (
    input  logic                    frame_clk,
    input  logic                    game_restart_n,
    timer_display_decoder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] work_q, work_d;
    logic [9:0] acc_q, acc_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] last_q, last_d;
    logic       pend_q, pend_d;
    logic [1:0] hund_q, hund_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       valid_q, valid_d;
    logic       low_q, low_d;
    logic       exp_q, exp_d;
    logic       blink_q, blink_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic [9:0] acc_adj;
    logic       blink_hold;
`ifdef TIMER_LEADING_ZERO_BLANK_EN
    logic [2:0] blank_q, blank_d;
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        pend_d  = pend_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        valid_d = 1'b0;
        low_d   = low_q;
        exp_d   = exp_q;
`ifdef TIMER_LEADING_ZERO_BLANK_EN
        blank_d = blank_q;
`endif

        // Add-3 correction on the ones and tens nibbles before each shift
        acc_adj = acc_q;
        if (acc_q[3:0] >= 4'd5) acc_adj[3:0] = acc_q[3:0] + 4'd3;
        if (acc_q[7:4] >= 4'd5) acc_adj[7:4] = acc_q[7:4] + 4'd3;

        case (state_q)
            IDLE: begin
                if (pend_q || (bus.clock_time != last_q)) begin
                    work_d  = bus.clock_time;
                    last_d  = bus.clock_time;
                    pend_d  = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {acc_d, work_d} = {acc_adj, work_q} << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = DONE;
            end
            DONE: begin
                hund_d  = acc_q[9:8];
                tens_d  = acc_q[7:4];
                ones_d  = acc_q[3:0];
                valid_d = 1'b1;
                // last_q still holds the value just converted
                low_d   = (last_q <= LOW_THRESH);
                exp_d   = (last_q == 8'd0);
`ifdef TIMER_LEADING_ZERO_BLANK_EN
                blank_d = {acc_q[9:8] == 2'd0,
                           (acc_q[9:8] == 2'd0) && (acc_q[7:4] == 4'd0),
                           1'b0};
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Forcing also applies on the edge where low_time is being cleared,
        // so a coincident counter wrap cannot leave the digits hidden.
        blink_hold = !low_q || !low_d || bus.lose_game || bus.win_game;
        if (blink_hold) begin
            bcnt_d  = '0;
            blink_d = 1'b1;
        end else if (bcnt_q == BLINK_FRAMES - 8'd1) begin
            bcnt_d  = '0;
            blink_d = !blink_q;
        end else begin
            bcnt_d  = bcnt_q + 8'd1;
            blink_d = blink_q;
        end
    end

    always_ff @(posedge frame_clk or negedge game_restart_n) begin
        if (!game_restart_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            pend_q  <= 1'b1;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            valid_q <= 1'b0;
            low_q   <= 1'b0;
            exp_q   <= 1'b0;
            blink_q <= 1'b1;
            bcnt_q  <= '0;
`ifdef TIMER_LEADING_ZERO_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            valid_q <= valid_d;
            low_q   <= low_d;
            exp_q   <= exp_d;
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
`ifdef TIMER_LEADING_ZERO_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign bus.bcd_hundreds = hund_q;
    assign bus.bcd_tens     = tens_q;
    assign bus.bcd_ones     = ones_q;
    assign bus.digits_valid = valid_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.low_time     = low_q;
    assign bus.time_expired = exp_q;
    assign bus.blink_on     = blink_q;
`ifdef TIMER_LEADING_ZERO_BLANK_EN
    assign bus.digit_blank  = blank_q;
`else
    assign bus.digit_blank  = 3'b000;
`endif

endmodule

// File: doc/timer_display_decoder.md
Name: timer_display_decoder

Overview:
- Reader side of the game countdown: samples the 8-bit binary `clock_time` value that the game timer publishes each second.
- Converts it serially (shift-and-add-3) into registered BCD digits for the HUD digit sprites.
- Drives a low-time blink flag and a time-expired flag for the HUD and game-over logic.
- Sits between the countdown timer and the HUD/sprite renderer; runs on the frame clock.

Parameters:
- LOW_THRESH, 8'd10, displayed value at or below which the low-time warning is active
- BLINK_FRAMES, 8'd15, frame_clk cycles per blink half-period while low-time is active

Ports:
- frame_clk  input  1  frame clock, rising-edge active
- game_restart_n  input  1  asynchronous active-low reset
- clock_time  input  8  binary seconds remaining, published by the countdown timer
- lose_game  input  1  game lost; freezes blink
- win_game  input  1  game won; freezes blink
- bcd_hundreds  output  2  hundreds digit (0-2)
- bcd_tens  output  4  tens digit (0-9)
- bcd_ones  output  4  ones digit (0-9)
- digits_valid  output  1  one-cycle pulse when the digit outputs update
- busy  output  1  conversion in progress
- low_time  output  1  displayed value <= LOW_THRESH
- blink_on  output  1  HUD digits visible this frame
- time_expired  output  1  displayed value == 0
- digit_blank  output  3  {hundreds, tens, ones} blank enables (see Optional Feature)

Behaviour:
- One clock (frame_clk). Reset is asynchronous and active-low (game_restart_n). All state is cleared on reset assertion, independent of frame_clk.
- Reset values:
  - Digits, digits_valid, busy, low_time, time_expired: 0.
  - blink_on: 1. digit_blank: 3'b000.
  - last_time: 0. pending: 1, so the first post-reset cycle starts a conversion.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Start condition: pending == 1 or clock_time != last_time.
  - On start: capture clock_time into the work register and into last_time; clear pending; clear the 10-bit BCD accumulator; clear iteration count; go to SHIFT.
- SHIFT, each edge:
  - Add 3 to each accumulator nibble that is >= 5 (ones and tens nibbles).
  - Left-shift {accumulator, work} by 1. Increment count.
  - After the 8th shift (count was 7), go to DONE.
- DONE:
  - Register accumulator into bcd_hundreds/tens/ones.
  - Pulse digits_valid for exactly one cycle.
  - Update low_time and time_expired from the converted binary value.
  - Go to IDLE.
- Latency: capture edge k, shifts on edges k+1..k+8, outputs and digits_valid at edge k+9. busy is 1 from edge k through edge k+8 and 0 at k+9.
- clock_time changes while busy are not lost. last_time is compared again in IDLE, so the newest value is converted next. Intermediate values may be skipped.
- A clock_time value that is unchanged never retriggers a conversion.
- Blink:
  - When low_time=0, or lose_game=1, or win_game=1: blink_on=1 and the blink counter is held at 0.
  - Otherwise the counter increments each frame_clk. On reaching BLINK_FRAMES-1 the counter wraps to 0 and blink_on toggles.
  - Counter width is 8 bits.
- Simultaneous: if low_time clears on the same edge the counter wraps, the forcing rule wins and blink_on=1.
- Reset mid-conversion aborts the conversion, returns to IDLE with pending=1, and leaves the digits cleared.

Optional Feature:
- Macro: TIMER_LEADING_ZERO_BLANK_EN.
- Defined: digit_blank is registered at DONE.
  - Hundreds blank when hundreds==0.
  - Tens blank when hundreds==0 and tens==0.
  - Ones is never blank.
- Undefined: digit_blank is tied to 3'b000.

Test Plan:
- Reset release with clock_time=60:
  - Capture on the first edge; digits_valid at edge 10.
  - Digits 0/6/0, low_time=0, time_expired=0, blink_on=1.
- clock_time=255 -> digits 2/5/5, one digits_valid pulse, busy high for 9 cycles.
- clock_time steps 11 -> 10:
  - low_time rises after conversion.
  - blink_on toggles every 15 frames (0 at frame 15, 1 at frame 30).
  - Set lose_game=1 -> blink_on forced 1 next edge, counter held.
- clock_time changed 40 -> 39 -> 38 within one conversion -> exactly two digits_valid pulses; final digits 0/3/8, no conversion of 39 required.
- clock_time=0 -> digits 0/0/0, time_expired=1, low_time=1.
  - With TIMER_LEADING_ZERO_BLANK_EN defined: digit_blank=3'b110.
  - With the macro undefined: digit_blank=3'b000.
- Assert game_restart_n low at shift 4 of converting 99:
  - All outputs go to reset values asynchronously.
  - After release, digits 0/9/9 appear 10 edges later.
